// File: rtl/sched_pkg.sv
// Shared types for the dispatch scheduler: instruction classes, queue entry
// layout and the decoder-flag classifier.
package sched_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned IMM_W    = 32;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_ADD,
        OP_MUL,
        OP_LOAD,
        OP_STORE,
        OP_ILL
    } op_class_e;

    typedef struct packed {
        op_class_e         cls;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [IMM_W-1:0]  imm;
    } q_entry_t;

    // Unrecognized wins over every class flag; no flag at all is undecodable.
    function automatic op_class_e classify(
        input logic is_add,
        input logic is_mul,
        input logic is_load,
        input logic is_store,
        input logic is_nop,
        input logic unrec
    );
        op_class_e c;
        c = OP_ILL;
        if (unrec)         c = OP_ILL;
        else if (is_add)   c = OP_ADD;
        else if (is_mul)   c = OP_MUL;
        else if (is_load)  c = OP_LOAD;
        else if (is_store) c = OP_STORE;
        else if (is_nop)   c = OP_NOP;
        return c;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never pending.
module reg_scoreboard
    import sched_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en_i,
    input  logic [REG_W-1:0] set_rd_i,
    input  logic             clr_en_i,
    input  logic [REG_W-1:0] clr_rd_i,
    input  logic [REG_W-1:0] rd_a_i,
    input  logic [REG_W-1:0] rd_b_i,
    input  logic [REG_W-1:0] rd_c_i,
    output logic             busy_a_o,
    output logic             busy_b_o,
    output logic             busy_c_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Clear is applied before set so a same-cycle set of the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) pending_d[clr_rd_i] = 1'b0;
        if (set_en_i) pending_d[set_rd_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign busy_a_o = pending_q[rd_a_i];
    assign busy_b_o = pending_q[rd_b_i];
    assign busy_c_o = pending_q[rd_c_i];

endmodule

// File: rtl/dispatch_scheduler.sv
// In-order issue queue: buffers decoded instructions and dispatches the head
// to its execution unit once the unit is ready and no register hazard remains.
module dispatch_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_type_add,
    input  logic             in_type_mul,
    input  logic             in_type_load,
    input  logic             in_type_store,
    input  logic             in_type_nop,
    input  logic             in_unrecognized,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    input  logic             add_ready,
    input  logic             mul_ready,
    input  logic             mem_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    output logic             add_issue,
    output logic             mul_issue,
    output logic             mem_issue,
    output logic             iss_is_store,
    output logic [4:0]       iss_rd,
    output logic [4:0]       iss_rs1,
    output logic [4:0]       iss_rs2,
    output logic [31:0]      iss_imm,
    output logic             illegal_drop,
    output logic             empty,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

    q_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic [PTR_W:0]    count_d;

    logic              add_issue_q, mul_issue_q, mem_issue_q, iss_is_store_q;
    logic [4:0]        iss_rd_q, iss_rs1_q, iss_rs2_q;
    logic [31:0]       iss_imm_q;
    logic              illegal_drop_q;
    logic [CNT_W-1:0]  stall_q;

    q_entry_t in_entry;
    q_entry_t head;
    logic     head_valid, enq, pop, issue, hazard, unit_ok, is_exec;
    logic     busy_rs1, busy_rs2, busy_rd, sb_set;

    assign in_entry.cls = classify(in_type_add, in_type_mul, in_type_load,
                                   in_type_store, in_type_nop, in_unrecognized);
    assign in_entry.rd  = in_rd;
    assign in_entry.rs1 = in_rs1;
    assign in_entry.rs2 = in_rs2;
    assign in_entry.imm = in_imm;

    assign head       = mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign in_ready   = (count_q != FULL_CNT);
    assign empty      = !head_valid;
    assign enq        = in_valid & in_ready;

    always_comb begin
        hazard  = 1'b0;
        unit_ok = 1'b0;
        is_exec = 1'b0;
        unique case (head.cls)
            OP_ADD:   begin is_exec = 1'b1; unit_ok = add_ready; hazard = busy_rs1 | busy_rs2 | busy_rd; end
            OP_MUL:   begin is_exec = 1'b1; unit_ok = mul_ready; hazard = busy_rs1 | busy_rs2 | busy_rd; end
            OP_LOAD:  begin is_exec = 1'b1; unit_ok = mem_ready; hazard = busy_rs1 | busy_rd; end
            OP_STORE: begin is_exec = 1'b1; unit_ok = mem_ready; hazard = busy_rs1 | busy_rs2; end
            default:  ;
        endcase
    end

    assign issue  = head_valid & is_exec & unit_ok & !hazard;
    // NOP and illegal heads drain unconditionally; they never touch a unit.
    assign pop    = issue | (head_valid & !is_exec);
    assign sb_set = issue & (head.cls != OP_STORE);

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en_i (sb_set),
        .set_rd_i (head.rd),
        .clr_en_i (wb_valid),
        .clr_rd_i (wb_rd),
        .rd_a_i   (head.rs1),
        .rd_b_i   (head.rs2),
        .rd_c_i   (head.rd),
        .busy_a_o (busy_rs1),
        .busy_b_o (busy_rs2),
        .busy_c_o (busy_rd)
    );

    always_comb begin
        count_d = count_q;
        if (enq && !pop)      count_d = count_q + 1'b1;
        else if (!enq && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= in_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            add_issue_q    <= 1'b0;
            mul_issue_q    <= 1'b0;
            mem_issue_q    <= 1'b0;
            iss_is_store_q <= 1'b0;
            iss_rd_q       <= '0;
            iss_rs1_q      <= '0;
            iss_rs2_q      <= '0;
            iss_imm_q      <= '0;
            illegal_drop_q <= 1'b0;
            stall_q        <= '0;
        end else begin
            add_issue_q    <= issue & (head.cls == OP_ADD);
            mul_issue_q    <= issue & (head.cls == OP_MUL);
            mem_issue_q    <= issue & ((head.cls == OP_LOAD) | (head.cls == OP_STORE));
            illegal_drop_q <= head_valid & (head.cls == OP_ILL);
            if (issue) begin
                iss_is_store_q <= (head.cls == OP_STORE);
                iss_rd_q       <= head.rd;
                iss_rs1_q      <= head.rs1;
                iss_rs2_q      <= head.rs2;
                iss_imm_q      <= head.imm;
            end
            if (head_valid && is_exec && !issue && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
        end
    end

    assign add_issue    = add_issue_q;
    assign mul_issue    = mul_issue_q;
    assign mem_issue    = mem_issue_q;
    assign iss_is_store = iss_is_store_q;
    assign iss_rd       = iss_rd_q;
    assign iss_rs1      = iss_rs1_q;
    assign iss_rs2      = iss_rs2_q;
    assign iss_imm      = iss_imm_q;
    assign illegal_drop = illegal_drop_q;
    assign stall_count  = stall_q;

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler: single-instruction vector table plus
// hand-written multi-cycle sequences for hazards, full queue and reset.
module tb_dispatch_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic        in_type_add, in_type_mul, in_type_load, in_type_store, in_type_nop, in_unrecognized;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        add_ready, mul_ready, mem_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        add_issue, mul_issue, mem_issue, iss_is_store;
    logic [4:0]  iss_rd, iss_rs1, iss_rs2;
    logic [31:0] iss_imm;
    logic        illegal_drop, empty;
    logic [15:0] stall_count;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    dispatch_scheduler #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_type_add(in_type_add), .in_type_mul(in_type_mul),
        .in_type_load(in_type_load), .in_type_store(in_type_store),
        .in_type_nop(in_type_nop), .in_unrecognized(in_unrecognized),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .add_ready(add_ready), .mul_ready(mul_ready), .mem_ready(mem_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .add_issue(add_issue), .mul_issue(mul_issue), .mem_issue(mem_issue),
        .iss_is_store(iss_is_store),
        .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_imm(iss_imm),
        .illegal_drop(illegal_drop), .empty(empty), .stall_count(stall_count)
    );

    // Flag vector order: {unrec, nop, store, load, mul, add}
    localparam logic [5:0] F_ADD = 6'b000001, F_MUL = 6'b000010, F_LD = 6'b000100,
                           F_ST  = 6'b001000, F_NOP = 6'b010000, F_ILL = 6'b100001;

    typedef struct {
        string       name;
        logic [5:0]  flags;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        e_add, e_mul, e_mem, e_store, e_ill;
        logic [4:0]  x_rd, x_rs1, x_rs2;
        logic [31:0] x_imm;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic a, input logic m, input logic e);
        add_ready = a; mul_ready = m; mem_ready = e;
    endtask

    task automatic drive(input logic [5:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        in_valid = 1'b1;
        {in_unrecognized, in_type_nop, in_type_store, in_type_load, in_type_mul, in_type_add} = f;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    task automatic enq(input logic [5:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
        drive(f, rd, rs1, rs2, imm);
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        wb_valid = 1'b0;
        wb_rd = '0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"add",   F_ADD, 5'd1, 5'd2, 5'd3, 32'h11,       1,0,0,0,0, 5'd1, 5'd2, 5'd3, 32'h11};
        vecs[1] = '{"mul",   F_MUL, 5'd4, 5'd5, 5'd6, 32'hdeadbeef, 0,1,0,0,0, 5'd4, 5'd5, 5'd6, 32'hdeadbeef};
        vecs[2] = '{"load",  F_LD,  5'd7, 5'd1, 5'd0, 32'h10,       0,0,1,0,0, 5'd7, 5'd1, 5'd0, 32'h10};
        vecs[3] = '{"store", F_ST,  5'd3, 5'd8, 5'd9, 32'hfffffffc, 0,0,1,1,0, 5'd3, 5'd8, 5'd9, 32'hfffffffc};
        vecs[4] = '{"nop",   F_NOP, 5'd9, 5'd9, 5'd9, 32'h55,       0,0,0,0,0, 5'd0, 5'd0, 5'd0, 32'h0};
        vecs[5] = '{"ill",   F_ILL, 5'd9, 5'd9, 5'd9, 32'h66,       0,0,0,0,1, 5'd0, 5'd0, 5'd0, 32'h0};

        reset = 1'b1;
        in_valid = 1'b0;
        drive(6'b0, '0, '0, '0, '0);
        in_valid = 1'b0;
        set_ready(1, 1, 1);
        wb_valid = 1'b0; wb_rd = '0;
        step(); step();
        reset = 1'b0;

        chk("rst_empty", empty, 1);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall", stall_count, 0);
        chk("rst_add_issue", add_issue, 0);
        chk("rst_iss_imm", iss_imm, 0);

        // Single-instruction table: enqueue into an empty queue, all units ready.
        foreach (vecs[i]) begin
            do_reset();
            set_ready(1, 1, 1);
            enq(vecs[i].flags, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            chk({vecs[i].name, "_queued_notempty"}, empty, 0);
            chk({vecs[i].name, "_queued_nopulse"}, {add_issue, mul_issue, mem_issue, illegal_drop}, 0);
            step();
            chk({vecs[i].name, "_add"}, add_issue, vecs[i].e_add);
            chk({vecs[i].name, "_mul"}, mul_issue, vecs[i].e_mul);
            chk({vecs[i].name, "_mem"}, mem_issue, vecs[i].e_mem);
            chk({vecs[i].name, "_ill"}, illegal_drop, vecs[i].e_ill);
            if (vecs[i].e_mem) chk({vecs[i].name, "_store"}, iss_is_store, vecs[i].e_store);
            chk({vecs[i].name, "_rd"}, iss_rd, vecs[i].x_rd);
            chk({vecs[i].name, "_rs1"}, iss_rs1, vecs[i].x_rs1);
            chk({vecs[i].name, "_rs2"}, iss_rs2, vecs[i].x_rs2);
            chk({vecs[i].name, "_imm"}, iss_imm, vecs[i].x_imm);
            chk({vecs[i].name, "_empty"}, empty, 1);
            chk({vecs[i].name, "_stall"}, stall_count, 0);
            step();
            chk({vecs[i].name, "_pulse_once"}, {add_issue, mul_issue, mem_issue, illegal_drop}, 0);
        end

        // Reset mid-run with two queued entries
        do_reset();
        set_ready(0, 0, 0);
        enq(F_ADD, 5'd1, 5'd2, 5'd3, 32'h1);
        enq(F_ADD, 5'd4, 5'd5, 5'd6, 32'h2);
        chk("midrst_pre_stall", stall_count, 1);
        chk("midrst_pre_empty", empty, 0);
        do_reset();
        chk("midrst_empty", empty, 1);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_stall", stall_count, 0);
        set_ready(1, 1, 1);
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 3; k++) begin
                step();
                seen = seen | add_issue | mul_issue | mem_issue;
            end
            chk("midrst_no_issue", seen, 0);
        end

        // Back-to-back independent ADD then MUL
        do_reset();
        set_ready(1, 1, 1);
        enq(F_ADD, 5'd1, 5'd2, 5'd3, 32'h0);
        enq(F_MUL, 5'd4, 5'd5, 5'd6, 32'h0);
        chk("b2b_add", add_issue, 1);
        chk("b2b_add_rd", iss_rd, 1);
        step();
        chk("b2b_mul", mul_issue, 1);
        chk("b2b_add_off", add_issue, 0);
        chk("b2b_mul_rd", iss_rd, 4);

        // RAW on x5
        do_reset();
        set_ready(1, 1, 1);
        enq(F_ADD, 5'd5, 5'd1, 5'd2, 32'h0);
        enq(F_ADD, 5'd6, 5'd5, 5'd5, 32'h0);
        chk("raw_first", add_issue, 1);
        step();
        chk("raw_held", add_issue, 0);
        chk("raw_stall1", stall_count, 1);
        step();
        chk("raw_stall2", stall_count, 2);
        step();
        wb_valid = 1'b1; wb_rd = 5'd5;
        step();
        wb_valid = 1'b0; wb_rd = '0;
        chk("raw_wb_cycle_held", add_issue, 0);
        chk("raw_stall4", stall_count, 4);
        step();
        chk("raw_issue", add_issue, 1);
        chk("raw_issue_rd", iss_rd, 6);
        chk("raw_stall_hold", stall_count, 4);

        // Full queue: 5th enqueue held until first pop
        do_reset();
        set_ready(0, 0, 0);
        for (int k = 0; k < 4; k++) enq(F_ADD, 5'(10 + k), 5'd0, 5'd0, 32'(k));
        chk("full_in_ready", in_ready, 0);
        drive(F_ADD, 5'd14, 5'd0, 5'd0, 32'h4);
        step();
        chk("full_still_blocked", in_ready, 0);
        chk("full_no_issue", add_issue, 0);
        add_ready = 1'b1;
        step();
        chk("full_pop0", add_issue, 1);
        chk("full_pop0_rd", iss_rd, 10);
        chk("full_ready_after_pop", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("full_pop1_rd", iss_rd, 11);
        for (int k = 2; k < 5; k++) begin
            step();
            chk("full_order_rd", iss_rd, 32'(10 + k));
            chk("full_order_add", add_issue, 1);
        end
        chk("full_drained", empty, 1);

        // NOP, illegal, then LOAD x7,0(x1)
        do_reset();
        set_ready(1, 1, 1);
        enq(F_NOP, 5'd0, 5'd0, 5'd0, 32'h0);
        enq(F_ILL, 5'd2, 5'd2, 5'd2, 32'h9);
        chk("nop_no_pulse", {add_issue, mul_issue, mem_issue, illegal_drop}, 0);
        enq(F_LD, 5'd7, 5'd1, 5'd0, 32'h0);
        chk("ill_drop", illegal_drop, 1);
        chk("ill_no_issue", {add_issue, mul_issue, mem_issue}, 0);
        step();
        chk("ld_mem", mem_issue, 1);
        chk("ld_ill_off", illegal_drop, 0);
        chk("ld_imm", iss_imm, 0);
        chk("ld_rd", iss_rd, 7);
        chk("ld_stall", stall_count, 0);

        // x0 writes never conflict; LOAD x3 then ADD x3 is a WAW wait
        do_reset();
        set_ready(1, 1, 1);
        enq(F_ADD, 5'd0, 5'd1, 5'd2, 32'h0);
        enq(F_ADD, 5'd0, 5'd1, 5'd2, 32'h0);
        chk("x0_first", add_issue, 1);
        step();
        chk("x0_second", add_issue, 1);
        chk("x0_stall", stall_count, 0);
        enq(F_LD, 5'd3, 5'd1, 5'd0, 32'h8);
        enq(F_ADD, 5'd3, 5'd1, 5'd2, 32'h0);
        chk("waw_load", mem_issue, 1);
        step();
        chk("waw_held", add_issue, 0);
        chk("waw_stall1", stall_count, 1);
        wb_valid = 1'b1; wb_rd = 5'd3;
        step();
        wb_valid = 1'b0; wb_rd = '0;
        chk("waw_wb_cycle_held", add_issue, 0);
        step();
        chk("waw_issue", add_issue, 1);
        chk("waw_issue_rd", iss_rd, 3);
        chk("waw_stall_final", stall_count, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
